// File: rtl/moka_rv32i_pkg.sv
// Shared types for the moka RV32I single-cycle core and its observers.
//   XLEN         : architectural datapath width
//   TRC_*        : bit positions inside trace_rec_t.flags
//   trace_rec_t  : one retire record (PC, instruction, write-back, store)
package moka_rv32i_pkg;

  localparam int unsigned XLEN = 32;

  localparam int unsigned TRC_REG_WR = 0;
  localparam int unsigned TRC_MEM_WR = 1;
  localparam int unsigned TRC_TAKEN  = 2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] instr;
    logic [4:0]      rd;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] maddr;
    logic [XLEN-1:0] mdata;
    logic [2:0]      flags;   // {taken, mem_wr, reg_wr}
  } trace_rec_t;

endpackage

// File: rtl/moka_rv32i_sc_retire_tracer_if.sv
// Retire-trace stream: valid/ready handshake plus the head record fields.
//   master : tracer side (drives valid and record fields, samples ready)
//   slave  : consumer side (scoreboard or debug port)
interface moka_rv32i_sc_retire_tracer_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  trace_valid;
  logic                  trace_ready;
  logic [DATA_WIDTH-1:0] trace_pc;
  logic [DATA_WIDTH-1:0] trace_pc_next;
  logic [DATA_WIDTH-1:0] trace_instr;
  logic [4:0]            trace_rd;
  logic [DATA_WIDTH-1:0] trace_wdata;
  logic [DATA_WIDTH-1:0] trace_maddr;
  logic [DATA_WIDTH-1:0] trace_mdata;
  logic [2:0]            trace_flags;

  modport master (
    output trace_valid, trace_pc, trace_pc_next, trace_instr, trace_rd,
           trace_wdata, trace_maddr, trace_mdata, trace_flags,
    input  trace_ready
  );

  modport slave (
    input  trace_valid, trace_pc, trace_pc_next, trace_instr, trace_rd,
           trace_wdata, trace_maddr, trace_mdata, trace_flags,
    output trace_ready
  );
endinterface

// File: rtl/moka_sync_fifo.sv
// Generic synchronous FIFO on a packed payload.
//   clk, rst_n (sync, active-low), clear (sync flush)
//   push/wdata : write side; a push while full is accepted only if a pop
//                happens on the same edge
//   pop/rdata  : read side; rdata is the head, forced to 0 while empty
//   full/empty : status
// Pointers carry one extra wrap bit: equal pointers mean empty, equal
// indices with differing wrap bits mean full.
module moka_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_pop;
  logic             do_push;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign do_pop  = pop & ~empty;
  // When full, the slot being written is the head being popped this edge;
  // the head is read combinationally, so the old value leaves intact.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !clear && do_push) mem[wptr[AW-1:0]] <= wdata;
  end

  assign rdata = empty ? '0 : mem[rptr[AW-1:0]];

endmodule

// File: rtl/moka_rv32i_sc_retire_tracer.sv
// Non-intrusive retire tracer for the single-cycle RV32I core.
//   clk, rst_n (sync, active-low), clear (sync flush of FIFO/counters/flag)
//   retire_en + datapath taps (pc, pc_next, instruction, rd, RegWrite, WD3,
//     MemWrite, ALUResult, RD2, PCSrc) : one record captured per retire edge
//   trc         : trace stream (master side), head record of the FIFO
//   retired_cnt : every retire edge, drops included (saturating)
//   dropped_cnt : records lost because the FIFO was full (saturating)
//   overflow    : sticky, set on the first drop
// DATA_WIDTH must equal moka_rv32i_pkg::XLEN, since the record is the
// package struct.
module moka_rv32i_sc_retire_tracer
  import moka_rv32i_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  retire_en,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic [DATA_WIDTH-1:0] pc_next,
  input  logic [DATA_WIDTH-1:0] instruction,
  input  logic [4:0]            rd,
  input  logic                  RegWrite,
  input  logic [DATA_WIDTH-1:0] WD3,
  input  logic                  MemWrite,
  input  logic [DATA_WIDTH-1:0] ALUResult,
  input  logic [DATA_WIDTH-1:0] RD2,
  input  logic                  PCSrc,
  moka_rv32i_sc_retire_tracer_if.master trc,
  output logic [CNT_WIDTH-1:0]  retired_cnt,
  output logic [CNT_WIDTH-1:0]  dropped_cnt,
  output logic                  overflow
);
  trace_rec_t rec;
  trace_rec_t head;
  logic       reg_wr;
  logic       full;
  logic       empty;
  logic       valid;
  logic       pop;
  logic       drop;

  // Writes to x0 are architecturally invisible, so they are not reported.
  always_comb begin
    rec                   = '0;
    reg_wr                = RegWrite & (rd != 5'd0);
    rec.pc                = pc;
    rec.pc_next           = pc_next;
    rec.instr             = instruction;
    rec.rd                = rd;
    rec.wdata             = reg_wr   ? WD3       : '0;
    rec.maddr             = MemWrite ? ALUResult : '0;
    rec.mdata             = MemWrite ? RD2       : '0;
    rec.flags[TRC_REG_WR] = reg_wr;
    rec.flags[TRC_MEM_WR] = MemWrite;
    rec.flags[TRC_TAKEN]  = PCSrc;
  end

  moka_sync_fifo #(
    .WIDTH ($bits(trace_rec_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .push  (retire_en),
    .wdata (rec),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign valid = ~empty;
  assign pop   = valid & trc.trace_ready;
  assign drop  = retire_en & full & ~pop;

  assign trc.trace_valid   = valid;
  assign trc.trace_pc      = head.pc;
  assign trc.trace_pc_next = head.pc_next;
  assign trc.trace_instr   = head.instr;
  assign trc.trace_rd      = head.rd;
  assign trc.trace_wdata   = head.wdata;
  assign trc.trace_maddr   = head.maddr;
  assign trc.trace_mdata   = head.mdata;
  assign trc.trace_flags   = head.flags;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      retired_cnt <= '0;
      dropped_cnt <= '0;
      overflow    <= 1'b0;
    end else begin
      if (retire_en && (retired_cnt != '1)) retired_cnt <= retired_cnt + CNT_WIDTH'(1);
      if (drop && (dropped_cnt != '1))      dropped_cnt <= dropped_cnt + CNT_WIDTH'(1);
      if (drop)                             overflow    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_moka_rv32i_sc_retire_tracer.sv
// Scoreboard bench for moka_rv32i_sc_retire_tracer: the stimulus side
// predicts pushes/drops and queues expected records; a monitor compares
// each popped head against the queue and checks head stability on stalls.
module tb_moka_rv32i_sc_retire_tracer;
  import moka_rv32i_pkg::*;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        retire_en;
  logic        clear;
  logic [31:0] pc, pc_next, instruction, WD3, ALUResult, RD2;
  logic [4:0]  rd;
  logic        RegWrite, MemWrite, PCSrc;
  logic [31:0] retired_cnt, dropped_cnt;
  logic        overflow;

  moka_rv32i_sc_retire_tracer_if #(.DATA_WIDTH(32)) trc ();

  moka_rv32i_sc_retire_tracer #(
    .DATA_WIDTH (32),
    .DEPTH      (DEPTH),
    .CNT_WIDTH  (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .retire_en   (retire_en),
    .clear       (clear),
    .pc          (pc),
    .pc_next     (pc_next),
    .instruction (instruction),
    .rd          (rd),
    .RegWrite    (RegWrite),
    .WD3         (WD3),
    .MemWrite    (MemWrite),
    .ALUResult   (ALUResult),
    .RD2         (RD2),
    .PCSrc       (PCSrc),
    .trc         (trc),
    .retired_cnt (retired_cnt),
    .dropped_cnt (dropped_cnt),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  trace_rec_t  q[$];
  int unsigned occ = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic trace_rec_t build_exp();
    trace_rec_t r;
    logic       rw;
    r         = '0;
    rw        = RegWrite && (rd != 5'd0);
    r.pc      = pc;
    r.pc_next = pc_next;
    r.instr   = instruction;
    r.rd      = rd;
    r.wdata   = rw ? WD3 : 32'h0;
    r.maddr   = MemWrite ? ALUResult : 32'h0;
    r.mdata   = MemWrite ? RD2 : 32'h0;
    r.flags   = {PCSrc, MemWrite, rw};
    return r;
  endfunction

  task automatic set_ins(input logic [31:0] p, input logic [31:0] pn, input logic [31:0] ins,
                         input logic [4:0] d, input logic rw, input logic [31:0] wd,
                         input logic mw, input logic [31:0] ad, input logic [31:0] sd,
                         input logic br);
    pc = p; pc_next = pn; instruction = ins; rd = d; RegWrite = rw; WD3 = wd;
    MemWrite = mw; ALUResult = ad; RD2 = sd; PCSrc = br;
  endtask

  // Predicts this cycle's edge, then advances to just after it.
  task automatic tick();
    logic popm;
    if (!rst_n || clear) begin
      q.delete();
      occ = 0;
    end else begin
      popm = (occ > 0) && trc.trace_ready;
      if (retire_en && !(occ == DEPTH && !popm)) begin
        q.push_back(build_exp());
        occ++;
      end
      if (popm) occ--;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor
  trace_rec_t got, prev_rec;
  logic       prev_valid = 1'b0;
  logic       prev_pop   = 1'b0;
  trace_rec_t exp_r;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n || clear) begin
        prev_valid = 1'b0;
        prev_pop   = 1'b0;
      end else begin
        got.pc      = trc.trace_pc;
        got.pc_next = trc.trace_pc_next;
        got.instr   = trc.trace_instr;
        got.rd      = trc.trace_rd;
        got.wdata   = trc.trace_wdata;
        got.maddr   = trc.trace_maddr;
        got.mdata   = trc.trace_mdata;
        got.flags   = trc.trace_flags;
        if (prev_valid && !prev_pop) begin
          chk("hold_valid", {63'h0, trc.trace_valid}, 64'h1);
          n_chk++;
          if (got !== prev_rec) begin
            n_fail++;
            $display("FAIL hold_rec: got pc %0h instr %0h expected pc %0h instr %0h",
                     got.pc, got.instr, prev_rec.pc, prev_rec.instr);
          end
        end
        if (trc.trace_valid && trc.trace_ready) begin
          n_chk++;
          if (q.size() == 0) begin
            n_fail++;
            $display("FAIL pop_unexpected: got pc %0h expected no record", got.pc);
          end else begin
            exp_r = q.pop_front();
            if (got !== exp_r) begin
              n_fail++;
              $display("FAIL pop_rec: got pc %0h pcn %0h ins %0h rd %0d wd %0h ma %0h md %0h fl %b expected pc %0h pcn %0h ins %0h rd %0d wd %0h ma %0h md %0h fl %b",
                       got.pc, got.pc_next, got.instr, got.rd, got.wdata, got.maddr, got.mdata, got.flags,
                       exp_r.pc, exp_r.pc_next, exp_r.instr, exp_r.rd, exp_r.wdata, exp_r.maddr, exp_r.mdata, exp_r.flags);
            end
          end
        end
        prev_valid = trc.trace_valid;
        prev_pop   = trc.trace_valid && trc.trace_ready;
        prev_rec   = got;
      end
    end
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; retire_en = 1'b0; trc.trace_ready = 1'b0;
    set_ins(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);

    // Reset then idle
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_valid", {63'h0, trc.trace_valid}, 64'h0);
    chk("rst_retired", {32'h0, retired_cnt}, 64'h0);
    chk("rst_dropped", {32'h0, dropped_cnt}, 64'h0);
    chk("rst_overflow", {63'h0, overflow}, 64'h0);
    chk("rst_empty_pc", {32'h0, trc.trace_pc}, 64'h0);

    // Single retire, consumer ready, FIFO empty
    trc.trace_ready = 1'b1;
    set_ins(32'h100, 32'h104, 32'h00500093, 5'd1, 1'b1, 32'h5, 1'b0, 32'h0, 32'h0, 1'b0);
    retire_en = 1'b1;
    tick();
    retire_en = 1'b0;
    chk("single_valid", {63'h0, trc.trace_valid}, 64'h1);
    chk("single_pc", {32'h0, trc.trace_pc}, 64'h100);
    chk("single_wdata", {32'h0, trc.trace_wdata}, 64'h5);
    chk("single_flags", {61'h0, trc.trace_flags}, 64'h1);
    tick();
    chk("single_popped", {63'h0, trc.trace_valid}, 64'h0);
    chk("single_retired", {32'h0, retired_cnt}, 64'h1);

    // x0 write plus store
    set_ins(32'h104, 32'h108, 32'h0AB02023, 5'd0, 1'b1, 32'h7, 1'b1, 32'h2000, 32'hAB, 1'b0);
    retire_en = 1'b1;
    tick();
    retire_en = 1'b0;
    chk("store_flags", {61'h0, trc.trace_flags}, 64'h2);
    chk("store_wdata", {32'h0, trc.trace_wdata}, 64'h0);
    chk("store_maddr", {32'h0, trc.trace_maddr}, 64'h2000);
    chk("store_mdata", {32'h0, trc.trace_mdata}, 64'hAB);
    tick();

    // Taken branch: no write-back, no store, masked data fields
    set_ins(32'h108, 32'h200, 32'h0E208C63, 5'd3, 1'b0, 32'h55, 1'b0, 32'h1234, 32'h99, 1'b1);
    retire_en = 1'b1;
    tick();
    retire_en = 1'b0;
    chk("branch_flags", {61'h0, trc.trace_flags}, 64'h4);
    chk("branch_pcnext", {32'h0, trc.trace_pc_next}, 64'h200);
    chk("branch_maddr", {32'h0, trc.trace_maddr}, 64'h0);
    tick();
    chk("empty_zero_pc", {32'h0, trc.trace_pc}, 64'h0);

    // Overflow: 10 retires, consumer stalled
    trc.trace_ready = 1'b0;
    retire_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_ins(32'(i * 4), 32'(i * 4 + 4), 32'h00000013, 5'd2, 1'b1, 32'(i + 16), 1'b0, 32'h0, 32'h0, 1'b0);
      tick();
    end
    retire_en = 1'b0;
    tick();
    chk("ovf_dropped", {32'h0, dropped_cnt}, 64'h2);
    chk("ovf_flag", {63'h0, overflow}, 64'h1);
    chk("ovf_retired", {32'h0, retired_cnt}, 64'd13);
    chk("ovf_head_pc", {32'h0, trc.trace_pc}, 64'h0);

    // Full with simultaneous push and pop: no drop
    trc.trace_ready = 1'b1;
    set_ins(32'h1000, 32'h1004, 32'h00000013, 5'd4, 1'b1, 32'hC0DE, 1'b0, 32'h0, 32'h0, 1'b0);
    retire_en = 1'b1;
    tick();
    retire_en = 1'b0;
    chk("fullpp_dropped", {32'h0, dropped_cnt}, 64'h2);
    chk("fullpp_retired", {32'h0, retired_cnt}, 64'd14);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 6) chk("drain_valid_last", {63'h0, trc.trace_valid}, 64'h1);
    end
    chk("drain_valid_fall", {63'h0, trc.trace_valid}, 64'h0);
    chk("drain_sb_empty", 64'(q.size()), 64'h0);

    // Clear mid-stream with a coincident retire
    trc.trace_ready = 1'b0;
    retire_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_ins(32'(32'h300 + i * 4), 32'(32'h304 + i * 4), 32'h00000013, 5'd5, 1'b1, 32'(i), 1'b0, 32'h0, 32'h0, 1'b0);
      tick();
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    retire_en = 1'b0;
    chk("clr_valid", {63'h0, trc.trace_valid}, 64'h0);
    chk("clr_retired", {32'h0, retired_cnt}, 64'h0);
    chk("clr_dropped", {32'h0, dropped_cnt}, 64'h0);
    chk("clr_overflow", {63'h0, overflow}, 64'h0);
    trc.trace_ready = 1'b1;
    tick(); tick();

    // Reset held mid-stream discards buffered records
    trc.trace_ready = 1'b0;
    retire_en = 1'b1;
    tick(); tick();
    retire_en = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_valid", {63'h0, trc.trace_valid}, 64'h0);
    chk("mrst_retired", {32'h0, retired_cnt}, 64'h0);
    trc.trace_ready = 1'b1;
    set_ins(32'h400, 32'h404, 32'h00A00193, 5'd3, 1'b1, 32'hA, 1'b0, 32'h0, 32'h0, 1'b0);
    retire_en = 1'b1;
    tick();
    retire_en = 1'b0;
    chk("post_rst_pc", {32'h0, trc.trace_pc}, 64'h400);
    tick(); tick();
    chk("post_rst_retired", {32'h0, retired_cnt}, 64'h1);
    chk("final_sb_empty", 64'(q.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1);
  end

endmodule
